// File: rtl/axi_bram_reader.sv
// AXI4-Lite read-only slave returning BRAM words, one read outstanding at a time.
// Define AXI_BRAM_READER_OUTREG_EN for a BRAM with its output register enabled (2-cycle latency).
module axi_bram_reader #(
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ADDR_WIDTH  = 16,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH = 10
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  output logic                        bram_porta_clk,
  output logic                        bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]  bram_porta_rddata
);

  localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH/8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    WAIT2 = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t                       state, state_nxt;
  logic [BRAM_ADDR_WIDTH-1:0]   addr_reg;
  logic [BRAM_DATA_WIDTH-1:0]   rdata_reg;
  logic                         ar_hs, load_rdata;

  assign ar_hs = s_axi_arvalid && s_axi_arready;

`ifdef AXI_BRAM_READER_OUTREG_EN
  assign load_rdata = (state == WAIT2);
`else
  assign load_rdata = (state == WAIT1);
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (ar_hs) state_nxt = WAIT1;
`ifdef AXI_BRAM_READER_OUTREG_EN
      WAIT1: state_nxt = WAIT2;
      WAIT2: state_nxt = VALID;
`else
      WAIT1: state_nxt = VALID;
`endif
      VALID: if (s_axi_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (state)
      IDLE:    s_axi_arready = 1'b1;
      VALID:   s_axi_rvalid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_reg  <= '0;
      rdata_reg <= '0;
    end else begin
      if (ar_hs)      addr_reg  <= s_axi_araddr[ADDR_LSB +: BRAM_ADDR_WIDTH];
      if (load_rdata) rdata_reg <= bram_porta_rddata;
    end
  end

  // Address goes straight through while idle so the BRAM samples it on the AR handshake edge.
  assign bram_porta_addr = s_axi_arready ? s_axi_araddr[ADDR_LSB +: BRAM_ADDR_WIDTH] : addr_reg;
  assign bram_porta_clk  = aclk;
  assign bram_porta_rst  = ~aresetn;

  assign s_axi_rdata   = rdata_reg;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_awready = 1'b0;
  assign s_axi_wready  = 1'b0;
  assign s_axi_bvalid  = 1'b0;
  assign s_axi_bresp   = 2'b00;

  logic unused;
  assign unused = ^{s_axi_araddr, s_axi_awaddr, s_axi_awvalid, s_axi_wdata,
                    s_axi_wstrb, s_axi_wvalid, s_axi_bready};

endmodule

// File: doc/axi_bram_reader.md
# axi_bram_reader

AXI4-Lite read-only slave that fetches words from a block RAM port and returns them on the AXI read channel. It is the read-side counterpart of the BRAM writer cores: the PS reads buffers filled by the PL (ADC captures, histograms) through this port. One read is outstanding at a time. The BRAM read latency is fixed at build time, and read data is registered so `s_axi_rdata` stays stable under backpressure.

## Interface
Parameters:
- `AXI_DATA_WIDTH`, 32, AXI data width; must equal `BRAM_DATA_WIDTH`.
- `AXI_ADDR_WIDTH`, 16, AXI byte-address width.
- `BRAM_DATA_WIDTH`, 32, BRAM word width.
- `BRAM_ADDR_WIDTH`, 10, BRAM word-address width.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `aclk` in 1: sole clock.
- `aresetn` in 1: asynchronous active-low reset.
- `s_axi_araddr` in AXI_ADDR_WIDTH: read address.
- `s_axi_arvalid` in 1, `s_axi_arready` out 1: read-address handshake.
- `s_axi_rdata` out AXI_DATA_WIDTH: read data.
- `s_axi_rresp` out 2: read response, constant 0 (OKAY).
- `s_axi_rvalid` out 1, `s_axi_rready` in 1: read-data handshake.
- Write channels `s_axi_awaddr`, `s_axi_awvalid`, `s_axi_wdata`, `s_axi_wstrb`, `s_axi_wvalid`, `s_axi_bready` are inputs and are ignored.
  - `s_axi_awready`, `s_axi_wready` and `s_axi_bvalid` are held at 0.
  - `s_axi_bresp` is held at 0.
- `bram_porta_clk` out 1: equals `aclk`.
- `bram_porta_rst` out 1: equals `~aresetn`.
- `bram_porta_addr` out BRAM_ADDR_WIDTH: word address.
- `bram_porta_rddata` in BRAM_DATA_WIDTH: read data from the BRAM.

## Operation
- `ADDR_LSB` = log2(AXI_DATA_WIDTH/8).
- Word address = `araddr[ADDR_LSB+BRAM_ADDR_WIDTH-1:ADDR_LSB]`.
  - Lower address bits are ignored.
  - Upper address bits are ignored, so the BRAM aliases across the AXI window.
- `bram_porta_addr` is `s_axi_araddr` slice while `arready`=1, otherwise the captured address register. The address therefore reaches the BRAM on the same edge as the AR handshake.
- FSM states:
  - IDLE: `arready`=1, `rvalid`=0. Moves on an AR handshake (`arvalid`&`arready` at an edge): captures the address and goes to WAIT1.
  - WAIT1: `arready`=0. Goes to WAIT2 if the macro is defined, otherwise loads `rdata_reg` from `bram_porta_rddata` and goes to VALID.
  - WAIT2 (macro only): loads `rdata_reg` and goes to VALID.
  - VALID: `rvalid`=1, `rdata`=`rdata_reg`, held stable. On `rready`=1 goes to IDLE.
- `rready` is ignored outside VALID.
- `arvalid` during a non-IDLE state is not accepted; the master must hold it.

## Timing
- Reset values: `arready`=1, `rvalid`=0, `rdata`=0, state IDLE, address register 0.
- Reset takes effect immediately, mid-transaction included. An in-flight read is discarded and no R beat is produced for it.
- Let AR handshake be at edge T. `rvalid` rises after edge T+1 (T+2 with the macro).
- If `rready` is already 1, the R handshake is at edge T+2 (T+3), and `arready` is 1 again after that edge.
- Maximum throughput: one read per 3 cycles (4 with the macro).
- If the R handshake and a new `arvalid` coincide, the new address is not accepted until the following cycle.
- Backpressure: `rvalid`=1 and `rdata` are constant until `rready`; any wait length is allowed.
- The BRAM address is held constant from the AR handshake until the R handshake.

## Configuration
- `AXI_BRAM_READER_OUTREG_EN`:
  - Defined: the BRAM is assumed to have its output register enabled (2-cycle read latency), and the WAIT2 state is compiled in.
  - Undefined: 1-cycle BRAM latency; WAIT2 is absent.

## Test plan
- Reset: hold `aresetn`=0 -> `arready`=1, `rvalid`=0, `rdata`=0, `bram_porta_rst`=1.
- Single read, macro off, BRAM model latency 1, word 5 = 0xDEADBEEF:
  - Stimulus: `araddr`=0x0014 with `rready`=1.
  - Required: `rvalid` for 1 cycle with 0xDEADBEEF at edge T+2, `rresp`=0.
- Backpressure: same read with `rready`=0 for 10 cycles -> `rvalid`=1 and `rdata` unchanged for all 10 cycles, `arready`=0 throughout, `bram_porta_addr`=5 throughout.
- Back-to-back reads, `arvalid` held continuously, addresses 0x0, 0x4, 0x8 -> three R beats, 3 cycles apart (4 with the macro, using a 2-latency model), data in order.
- Aliasing and misalignment: `araddr`=0x1003 with BRAM_ADDR_WIDTH=10 -> `bram_porta_addr`=0 (word 0x400 wraps to 0).
- Reset in WAIT1 or VALID -> `rvalid` drops immediately, next read after reset returns correct data, and no stale beat appears. Any write attempt (`awvalid`=`wvalid`=1) gets no `awready`/`wready`/`bvalid` response.
